// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the mem_ram_arbiter slice.
//   state_t        : transaction FSM states
//   MAX_CH         : upper bound on requester channels
//   ERR_RDATA      : read data returned for out-of-range accesses
//   addr_in_range(): byte-address window check against base/span
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_t;

  localparam int unsigned MAX_CH    = 8;
  localparam logic [31:0] ERR_RDATA = 32'h0;

  // span is in bytes and one bit wider than an address so a full 4 GiB
  // window still fits.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [32:0] span);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, base};
    return (addr >= base) && (off < span);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req   : request vector, one bit per channel
//   ptr   : channel with highest priority this round
//   grant : one-hot grant (all zero when no request)
//   idx   : binary index of the granted channel
// Search starts at ptr and wraps modulo N.
module rr_arbiter #(
  parameter int unsigned N    = 2,
  parameter int unsigned IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] idx
);

  always_comb begin
    logic        found;
    int unsigned c;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      c = 32'(ptr) + i;
      if (c >= N) c = c - N;
      if (!found && req[c[IDXW-1:0]]) begin
        found               = 1'b1;
        grant[c[IDXW-1:0]]  = 1'b1;
        idx                 = IDXW'(c);
      end
    end
  end

endmodule

// File: rtl/mem_ram_arbiter.sv
// mem_ram_arbiter: single-port 32-bit word RAM shared by NUM_CH
// PicoRV32-native-bus requesters through a round-robin arbiter.
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   mem_valid/instr       : per-channel request and fetch flag
//   mem_addr/wdata/wstrb  : per-channel packed request fields (32/32/4 bits)
//   mem_ready/rdata/err   : per-channel completion pulse, read data, range error
//   busy                  : FSM is not idle
// One transaction in flight: IDLE -> ACCESS -> [WAIT] -> RESP -> IDLE.
import mem_arb_pkg::*;

module mem_ram_arbiter #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned READ_LAT    = 1,
  parameter              INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     mem_valid,
  input  logic [NUM_CH-1:0]     mem_instr,
  input  logic [NUM_CH*32-1:0]  mem_addr,
  input  logic [NUM_CH*32-1:0]  mem_wdata,
  input  logic [NUM_CH*4-1:0]   mem_wstrb,
  output logic [NUM_CH-1:0]     mem_ready,
  output logic [NUM_CH*32-1:0]  mem_rdata,
  output logic [NUM_CH-1:0]     mem_err,
  output logic                  busy
);

  localparam int unsigned IDXW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] DEPTH_BYTES = 33'(DEPTH_WORDS) << 2;

  state_t            state;
  logic [IDXW-1:0]   ptr;
  logic [IDXW-1:0]   ch_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              instr_q;
  logic              err_q;
  logic [31:0]       rdata_q [NUM_CH];

  logic [NUM_CH-1:0] grant_oh;
  logic [IDXW-1:0]   grant_idx;

  logic [31:0]       ram [DEPTH_WORDS];
  logic [31:0]       rd_q1;
  logic [31:0]       ram_dout;

  logic              is_write;
  logic              hit;
  logic [31:0]       offset;
  logic [AW-1:0]     widx;
  logic              resp_load;
  logic [31:0]       resp_rdata;

  rr_arbiter #(
    .N    (NUM_CH),
    .IDXW (IDXW)
  ) u_rr (
    .req   (mem_valid),
    .ptr   (ptr),
    .grant (grant_oh),
    .idx   (grant_idx)
  );

  always_comb begin
    is_write   = (wstrb_q != 4'b0000) && !instr_q;
    hit        = addr_in_range(addr_q, BASE_ADDR, DEPTH_BYTES);
    offset     = addr_q - BASE_ADDR;
    widx       = AW'(offset >> 2);
    resp_load  = err_q || !is_write;
    resp_rdata = err_q ? ERR_RDATA : ram_dout;
  end

  // Transaction FSM; busy is registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      ptr     <= '0;
      ch_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      instr_q <= 1'b0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) rdata_q[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant_oh) begin
            ch_q    <= grant_idx;
            addr_q  <= mem_addr[32*grant_idx +: 32];
            wdata_q <= mem_wdata[32*grant_idx +: 32];
            wstrb_q <= mem_wstrb[4*grant_idx +: 4];
            instr_q <= mem_instr[grant_idx];
            state   <= ACCESS;
            busy    <= 1'b1;
          end
        end
        ACCESS: begin
          err_q <= !hit;
          state <= (READ_LAT == 2 && !is_write) ? WAIT : RESP;
        end
        WAIT: begin
          state <= RESP;
        end
        RESP: begin
          if (resp_load) rdata_q[ch_q] <= resp_rdata;
          ptr   <= (ch_q == IDXW'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Byte-enable RAM; reset on the ACCESS edge suppresses the write.
  always_ff @(posedge clk) begin
    if (state == ACCESS && !reset && hit) begin
      if (is_write) begin
        for (int unsigned k = 0; k < 4; k++)
          if (wstrb_q[k]) ram[widx][8*k +: 8] <= wdata_q[8*k +: 8];
      end else begin
        rd_q1 <= ram[widx];
      end
    end
  end

  if (READ_LAT == 2) begin : g_oreg
    logic [31:0] rd_q2;
    always_ff @(posedge clk) rd_q2 <= rd_q1;
    assign ram_dout = rd_q2;
  end else begin : g_noreg
    assign ram_dout = rd_q1;
  end

  // Ready/err qualify the registered RESP state with the live valid so a
  // master that withdrew gets no pulse. Read data bypasses rdata_q during
  // RESP so it is valid together with mem_ready; rdata_q then holds it.
  always_comb begin
    mem_ready = '0;
    mem_err   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) mem_rdata[32*i +: 32] = rdata_q[i];
    if (state == RESP && !reset) begin
      mem_ready[ch_q] = mem_valid[ch_q];
      mem_err[ch_q]   = mem_valid[ch_q] & err_q;
      if (resp_load) mem_rdata[32*ch_q +: 32] = resp_rdata;
    end
  end

endmodule
